// File: rtl/ram_pair_reader_pkg.sv
// Shared definitions for the sorted RAM pair read-back engine.
//   state_e  : controller state encoding
//   SrcLow / SrcHigh : values carried on dout_src
package ram_pair_reader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReadL,
    StReadH,
    StDrain,
    StDone
  } state_e;

  localparam logic SrcLow  = 1'b0;
  localparam logic SrcHigh = 1'b1;

endpackage

// File: rtl/ram_pair_reader_rd_ptr_cnt.sv
// Read pointer for one RAM of the pair.
//   clk, reset : clock, synchronous active-high reset
//   clr        : force pointer to 0
//   en         : advance pointer (held once the last entry is reached)
//   limit      : latched entry count (1..2^addr_size while in use)
//   ptr        : current RAM address
//   last       : ptr addresses the final valid entry (ptr == limit-1)
module rd_ptr_cnt #(
  parameter int unsigned addr_size = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 en,
  input  logic [addr_size:0]   limit,
  output logic [addr_size-1:0] ptr,
  output logic                 last
);

  logic [addr_size-1:0] ptr_q, ptr_d;

  // Compare one bit wider than the pointer so a full RAM (limit = 2^addr_size)
  // ends at the top address instead of wrapping.
  assign last = (({1'b0, ptr_q} + {{addr_size{1'b0}}, 1'b1}) == limit);

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en && !last) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ram_pair_reader.sv
// Streams the low RAM entries, then the high RAM entries, through a registered
// valid/ready output, each word tagged with its source RAM and address.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a pass (sampled only in idle)
//   l_count, h_count    : valid entry counts, latched and clamped on start
//   l_addr/l_data       : low RAM read port (combinational read)
//   h_addr/h_data       : high RAM read port (combinational read)
//   dout, dout_src,
//   dout_addr           : streamed word, source RAM, source address
//   dout_valid/ready    : output handshake
//   busy                : pass in progress (registered view of the read/drain states)
//   done                : one-cycle pulse at pass completion (registered, so it
//                         appears the cycle after the done state)
module ram_pair_reader
  import ram_pair_reader_pkg::*;
#(
  parameter int unsigned addr_size = 4,
  parameter int unsigned word_size = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [addr_size:0]   l_count,
  input  logic [addr_size:0]   h_count,
  output logic [addr_size-1:0] l_addr,
  input  logic [word_size-1:0] l_data,
  output logic [addr_size-1:0] h_addr,
  input  logic [word_size-1:0] h_data,
  output logic [word_size-1:0] dout,
  output logic                 dout_src,
  output logic [addr_size-1:0] dout_addr,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 done
);

  localparam logic [addr_size:0] FullCount = {1'b1, {addr_size{1'b0}}};

  state_e state_q, state_d;

  logic [addr_size:0]   l_cnt_q, l_cnt_d, h_cnt_q, h_cnt_d;
  logic [addr_size:0]   l_clamp, h_clamp;
  logic [word_size-1:0] dout_q, dout_d;
  logic                 src_q, src_d;
  logic [addr_size-1:0] daddr_q, daddr_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 adv;
  logic                 l_clr, h_clr, l_en, h_en, l_last, h_last;

  // Output register is free, or is being emptied this cycle.
  assign adv = !valid_q || dout_ready;

  assign l_clamp = (l_count > FullCount) ? FullCount : l_count;
  assign h_clamp = (h_count > FullCount) ? FullCount : h_count;

  rd_ptr_cnt #(
    .addr_size(addr_size)
  ) u_l_ptr (
    .clk  (clk),
    .reset(reset),
    .clr  (l_clr),
    .en   (l_en),
    .limit(l_cnt_q),
    .ptr  (l_addr),
    .last (l_last)
  );

  rd_ptr_cnt #(
    .addr_size(addr_size)
  ) u_h_ptr (
    .clk  (clk),
    .reset(reset),
    .clr  (h_clr),
    .en   (h_en),
    .limit(h_cnt_q),
    .ptr  (h_addr),
    .last (h_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath loads.
  always_comb begin
    state_d = state_q;
    l_cnt_d = l_cnt_q;
    h_cnt_d = h_cnt_q;
    dout_d  = dout_q;
    src_d   = src_q;
    daddr_d = daddr_q;
    valid_d = valid_q;
    l_clr   = 1'b0;
    h_clr   = 1'b0;
    l_en    = 1'b0;
    h_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          l_cnt_d = l_clamp;
          h_cnt_d = h_clamp;
          l_clr   = 1'b1;
          h_clr   = 1'b1;
          if (l_clamp != '0) begin
            state_d = StReadL;
          end else if (h_clamp != '0) begin
            state_d = StReadH;
          end else begin
            state_d = StDone;
          end
        end
      end
      StReadL: begin
        if (adv) begin
          dout_d  = l_data;
          src_d   = SrcLow;
          daddr_d = l_addr;
          valid_d = 1'b1;
          l_en    = 1'b1;
          if (l_last) begin
            state_d = (h_cnt_q != '0) ? StReadH : StDrain;
          end
        end
      end
      StReadH: begin
        if (adv) begin
          dout_d  = h_data;
          src_d   = SrcHigh;
          daddr_d = h_addr;
          valid_d = 1'b1;
          h_en    = 1'b1;
          if (h_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Final word leaves; nothing follows it.
        if (adv) begin
          valid_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy_d = (state_q == StReadL) || (state_q == StReadH) || (state_q == StDrain);
    done_d = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_cnt_q <= '0;
      h_cnt_q <= '0;
      dout_q  <= '0;
      src_q   <= SrcLow;
      daddr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      l_cnt_q <= l_cnt_d;
      h_cnt_q <= h_cnt_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
      daddr_q <= daddr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_src   = src_q;
  assign dout_addr  = daddr_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
